// File: rtl/rt8_final_cpa.sv
// -----------------------------------------------------------------------------
// rt8_final_cpa
//   Final carry-propagate stage after the radix-8 approximate compressor row.
//   It adds the per-column sum and carry vectors, and optionally the error
//   compensation vector, in a 2-stage pipeline. A saturating counter records
//   how many columns were flagged as approximate.
//
//   Optional feature macro: RT8_ERR_COMP_EN
//     defined   : err_vec<<1 is a third operand. A 3:2 carry-save row merges
//                 the three operands before the low-half add.
//     undefined : err_vec only drives result_err and err_cnt.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  input beat handshake
//   sum_vec         column sum bits, bit i weight 2^i
//   carry_vec       column carry bits, bit i weight 2^(i+1)
//   err_vec         column error flags, bit i weight 2^(i+1) when compensating
//   out_valid/ready result handshake
//   result          W+3-bit final sum
//   result_err      OR of err_vec for the beat
//   clr_cnt         synchronous clear of err_cnt (wins over a same-cycle count)
//   err_cnt         saturating count of flagged columns
//
// Handshake: a beat moves on a clock edge when valid and ready are both high.
//   A producer must hold valid and data steady until it is accepted. A held
//   output stays unchanged while out_valid is high and out_ready is low.
//   in_ready is combinational from out_ready through the pipeline.
// -----------------------------------------------------------------------------
module rt8_final_cpa #(
   parameter int W  = 16,
   parameter int CW = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   sum_vec,
   input  logic [W-1:0]   carry_vec,
   input  logic [W-1:0]   err_vec,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W+2:0]   result,
   output logic           result_err,
   input  logic           clr_cnt,
   output logic [CW-1:0]  err_cnt
);

   localparam int H  = W/2 + 1;            // low-half width
   localparam int UW = W + 2 - H;          // upper operand slice width
   localparam int PW = $clog2(W + 1);      // popcount width
   localparam int SW = ((CW > PW) ? CW : PW) + 1;
   localparam logic [CW-1:0] CNT_MAX = '1;

   // pipeline state
   logic            r_s1_valid;
   logic [H-1:0]    r_lo;
   logic            r_lo_c;
   logic [UW-1:0]   r_hi_x;
   logic [UW-1:0]   r_hi_y;
   logic            r_s1_err;
   logic            r_out_valid;
   logic [W+2:0]    r_result;
   logic            r_result_err;
   logic [CW-1:0]   r_cnt;

   logic            w_adv1, w_adv2, w_accept;
   logic [W+1:0]    w_op_x, w_op_y;
   logic [H:0]      w_lo_sum;
   logic [UW:0]     w_hi_sum;
   logic [PW-1:0]   w_pop;
   logic [SW-1:0]   w_cnt_sum;
   logic [CW-1:0]   w_cnt_next;

   // ---------------- handshake ----------------
   always_comb begin
      w_adv2   = !r_out_valid || out_ready;
      w_adv1   = !r_s1_valid || w_adv2;
      w_accept = in_valid && w_adv1;
   end

   assign in_ready = w_adv1;

   // ---------------- operand formation ----------------
`ifdef RT8_ERR_COMP_EN
   logic [W:0] w_a, w_b, w_e;
   always_comb begin
      w_a = {1'b0, sum_vec};
      w_b = {carry_vec, 1'b0};
      w_e = {err_vec, 1'b0};
      // carry-save row: sum bits stay in place, majority bits move up one
      w_op_x = {1'b0, w_a ^ w_b ^ w_e};
      w_op_y = {(w_a & w_b) | (w_a & w_e) | (w_b & w_e), 1'b0};
   end
`else
   always_comb begin
      w_op_x = {2'b00, sum_vec};
      w_op_y = {1'b0, carry_vec, 1'b0};
   end
`endif

   assign w_lo_sum = {1'b0, w_op_x[H-1:0]} + {1'b0, w_op_y[H-1:0]};

   // ---------------- stage 1 ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_lo       <= '0;
         r_lo_c     <= 1'b0;
         r_hi_x     <= '0;
         r_hi_y     <= '0;
         r_s1_err   <= 1'b0;
      end else if (w_adv1) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_lo     <= w_lo_sum[H-1:0];
            r_lo_c   <= w_lo_sum[H];
            r_hi_x   <= w_op_x[W+1:H];
            r_hi_y   <= w_op_y[W+1:H];
            r_s1_err <= |err_vec;
         end
      end
   end

   // ---------------- stage 2 ----------------
   assign w_hi_sum = {1'b0, r_hi_x} + {1'b0, r_hi_y} + {{UW{1'b0}}, r_lo_c};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_result     <= '0;
         r_result_err <= 1'b0;
      end else if (w_adv2) begin
         // an empty stage 1 moves in as a bubble and clears out_valid
         r_out_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_result     <= {w_hi_sum, r_lo};
            r_result_err <= r_s1_err;
         end
      end
   end

   assign out_valid  = r_out_valid;
   assign result     = r_result;
   assign result_err = r_result_err;

   // ---------------- error counter ----------------
   always_comb begin
      w_pop = '0;
      for (int i = 0; i < W; i++) begin
         w_pop = w_pop + PW'(err_vec[i]);
      end
   end

   always_comb begin
      w_cnt_sum  = SW'(r_cnt) + SW'(w_pop);
      w_cnt_next = (w_cnt_sum > SW'(CNT_MAX)) ? CNT_MAX : w_cnt_sum[CW-1:0];
   end

   // counting is tied to accept, so a downstream stall does not delay it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clr_cnt) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= w_cnt_next;
      end
   end

   assign err_cnt = r_cnt;

endmodule

// File: tb/tb_rt8_final_cpa.sv
module tb_rt8_final_cpa;
  localparam int W  = 8;
  localparam int CW = 4;
  localparam int RW = W + 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  sum_vec = '0;
  logic [W-1:0]  carry_vec = '0;
  logic [W-1:0]  err_vec = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [RW-1:0] result;
  logic          result_err;
  logic          clr_cnt = 1'b0;
  logic [CW-1:0] err_cnt;

  rt8_final_cpa #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_vec(sum_vec), .carry_vec(carry_vec), .err_vec(err_vec),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_err(result_err),
    .clr_cnt(clr_cnt), .err_cnt(err_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // {result_err, result} for one beat, straight from column weights
  function automatic logic [RW:0] model_beat(input logic [W-1:0] s, c, e);
    int unsigned total;
    logic [RW:0] r;
    total = s + 2 * c;
`ifdef RT8_ERR_COMP_EN
    total = total + 2 * e;
`endif
    r = {(e != 0), RW'(total)};
    return r;
  endfunction

  logic [RW:0] exp_q[$];
  int          m_cnt = 0;
  int          run = 0;
  int          max_run = 0;
  logic        hold = 1'b0;
  logic [RW-1:0] hold_res = '0;

  // ---------------- scoreboard / monitor ----------------
  // samples 1 ns before every rising edge, when inputs and outputs are settled
  always begin
    logic [RW:0] e;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      exp_q.delete();
      m_cnt = 0;
      hold  = 1'b0;
      run   = 0;
    end else begin
      if (out_valid) begin
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (hold && out_valid) chk("hold_stable", 32'(result), 32'(hold_res));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("result", 32'(result), 32'(e[RW-1:0]));
          chk("result_err", 32'(result_err), 32'(e[RW]));
        end
      end
      hold     = out_valid && !out_ready;
      hold_res = result;
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
      if (clr_cnt) begin
        m_cnt = 0;
      end else if (in_valid && in_ready) begin
        m_cnt = m_cnt + $countones(err_vec);
        if (m_cnt > (1 << CW) - 1) m_cnt = (1 << CW) - 1;
      end
      if (in_valid && in_ready) exp_q.push_back(model_beat(sum_vec, carry_vec, err_vec));
    end
  end

  // ---------------- driver tasks ----------------
  // presents one beat and returns at the sample point just before it is taken
  task automatic send(input logic [W-1:0] s, c, e, input logic clr, output int waits);
    @(negedge clk);
    in_valid  = 1'b1;
    sum_vec   = s;
    carry_vec = c;
    err_vec   = e;
    clr_cnt   = clr;
    waits     = 0;
    forever begin
      #4;
      if (in_ready) break;
      waits++;
      if (waits > 50) begin
        chk("send_timeout", 32'(waits), 32'(0));
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  logic [W-1:0] tb_s[10] = '{8'h00, 8'hFF, 8'h12, 8'h80, 8'h7F, 8'hA5, 8'h01, 8'h3C, 8'hFE, 8'h55};
  logic [W-1:0] tb_c[10] = '{8'h00, 8'h01, 8'h34, 8'h80, 8'hFF, 8'h5A, 8'h02, 8'hC3, 8'hFE, 8'hAA};
  logic [W-1:0] tb_e[10] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h80, 8'h00, 8'h03, 8'h00, 8'h10, 8'h00};

  initial begin
    int w;
    int low_seen;
    int k;
    logic rdy3;

    // reset state
    #2;
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_result_err", 32'(result_err), 32'(0));
    chk("rst_err_cnt", 32'(err_cnt), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single beat: 0x0F + 2*0x01 = 0x011, two edges from accept to out_valid
    send(8'h0F, 8'h01, 8'h00, 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    chk("lat_cycle1_valid", 32'(out_valid), 32'(0));
    @(negedge clk);
    #4;
    chk("lat_cycle2_valid", 32'(out_valid), 32'(1));
    chk("single_result", 32'(result), 32'h011);
    chk("single_result_err", 32'(result_err), 32'(0));
    chk("single_err_cnt", 32'(err_cnt), 32'(0));

    // maximum operands
    send(8'hFF, 8'hFF, 8'hFF, 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    #4;
    chk("max_err_cnt", 32'(err_cnt), 32'(8));
    @(negedge clk);
    #4;
    chk("max_valid", 32'(out_valid), 32'(1));
`ifdef RT8_ERR_COMP_EN
    chk("max_result", 32'(result), 32'h4FB);
`else
    chk("max_result", 32'(result), 32'h2FD);
`endif
    chk("max_result_err", 32'(result_err), 32'(1));
    idle(3);

    // back-to-back 10 beats
    low_seen = 0;
    max_run  = 0;
    for (int i = 0; i < 10; i++) begin
      send(tb_s[i], tb_c[i], tb_e[i], 1'b0, w);
      low_seen += w;
    end
    idle(5);
    chk("b2b_in_ready_low", 32'(low_seen), 32'(0));
    chk("b2b_valid_run", 32'(max_run), 32'(10));

    // stall: out_ready low, in_valid held for 5 cycles
    k = 0;
    rdy3 = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc > 0) @(negedge clk);
      in_valid  = 1'b1;
      sum_vec   = tb_s[k];
      carry_vec = tb_c[k];
      err_vec   = tb_e[k];
      #4;
      if (cyc == 2) rdy3 = in_ready;
      if (in_ready) k++;
    end
    chk("stall_accepted", 32'(k), 32'(2));
    chk("stall_in_ready_3rd", 32'(rdy3), 32'(0));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = k; i < 6; i++) send(tb_s[i], tb_c[i], tb_e[i], 1'b0, w);
    idle(5);
    chk("stall_drained", 32'(exp_q.size()), 32'(0));

    // saturating counter
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    #4;
    chk("cnt_cleared", 32'(err_cnt), 32'(0));
    for (int i = 0; i < 3; i++) send(8'h10, 8'h20, 8'h3F, 1'b0, w);
    idle(1);
    #4;
    chk("cnt_saturated", 32'(err_cnt), 32'(15));
    send(8'h01, 8'h01, 8'h01, 1'b1, w);
    idle(1);
    #4;
    chk("cnt_clear_wins", 32'(err_cnt), 32'(0));
    idle(4);

    // reset with 2 beats in flight
    @(negedge clk);
    out_ready = 1'b0;
    send(8'h11, 8'h22, 8'h01, 1'b0, w);
    send(8'h33, 8'h44, 8'h00, 1'b0, w);
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_result", 32'(result), 32'(0));
    chk("arst_err_cnt", 32'(err_cnt), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #4;
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    repeat (5) @(negedge clk);
    #4;
    chk("post_rst_no_stale", 32'(out_valid), 32'(0));
    chk("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
